pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL use a single clock and a reset that is synchronous and active-high, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled only on the rising edge of clk.
REQ-004 opcode  input  14  instruction currently returned by the ROM for address counter (same cycle, combinational path).
REQ-005 skip  input  1  ALU result requests skipping the next instruction; valid in the same cycle as opcode.
REQ-006 stall  input  1  holds all sequencer state when high.
REQ-007 counter  output  11  program address driven to the ROM, registered.
REQ-008 stack_ptr  output  3  registered pointer to the next free stack slot.
REQ-009 stk_ovf  output  1  sticky flag: a push occurred while the stack held 8 entries.
REQ-010 stk_unf  output  1  sticky flag: a pop occurred while the stack held 0 entries.
REQ-011 retlw_valid  output  1  registered; high for one cycle after a RETLW executes.
REQ-012 retlw_k  output  8  registered literal from the executed RETLW; valid while retlw_valid is high.

Function
REQ-013 Decode SHALL be: GOTO when opcode[13:11]=3'b101; CALL when opcode[13:11]=3'b100; RETURN when opcode=14'h0008; RETLW when opcode[13:10]=4'b1101; any other value is SEQ.
REQ-014 The branch target SHALL be opcode[10:0].
REQ-015 Next-counter behaviour per decoded instruction:
- SEQ with skip=0: counter+1.
- SEQ with skip=1: counter+2.
- GOTO: target.
- CALL: target.
- RETURN and RETLW: the popped stack entry.
REQ-016 The skip input SHALL be ignored when the opcode decodes as GOTO, CALL, RETURN or RETLW.
REQ-017 All counter arithmetic SHALL be modulo 2^11:
- 0x7FF+1 = 0x000.
- 0x7FF+2 = 0x001.
- 0x7FE+2 = 0x000.
REQ-018 The stack SHALL be 8 entries of 11 bits with a circular 3-bit pointer; an internal depth counter SHALL track occupancy in the range 0..8.
REQ-019 A push (CALL) SHALL:
- write counter+1 (mod 2^11) to stack[stack_ptr];
- set stack_ptr to stack_ptr+1 (mod 8);
- increment depth, saturating at 8.
REQ-020 A push at depth 8 SHALL overwrite the oldest entry, leave depth at 8, and set stk_ovf.
REQ-021 A pop (RETURN or RETLW) SHALL:
- set stack_ptr to stack_ptr-1 (mod 8);
- load counter from stack[stack_ptr-1];
- decrement depth, saturating at 0.
REQ-022 A pop at depth 0 SHALL still perform the pointer decrement and the stale-entry load, leave depth at 0, and set stk_unf.
REQ-023 stk_ovf and stk_unf SHALL remain set until reset.
REQ-024 On RETLW, retlw_k SHALL be loaded with opcode[7:0] and retlw_valid SHALL be 1 in the following cycle.
REQ-025 In every other non-stalled cycle, retlw_valid SHALL be 0 and retlw_k SHALL hold its value.
REQ-026 While stall=1, the following SHALL all hold their values: counter, stack contents, stack_ptr, depth, both flags, and retlw_k.
REQ-027 While stall=1, retlw_valid SHALL be forced to 0; the RETLW pulse SHALL not repeat after the stall releases unless a new RETLW executes.
REQ-028 Priority SHALL be: reset over stall over instruction decode.
REQ-029 Latency: each decision SHALL take effect on counter at the next rising edge of clk; there is no flush cycle.

Reset
REQ-030 When reset=1 at a rising edge of clk, the block SHALL set:
- counter=0;
- stack_ptr=0 and depth=0;
- all 8 stack entries to 0;
- stk_ovf=0 and stk_unf=0;
- retlw_valid=0 and retlw_k=0.
REQ-031 A reset asserted in the middle of a CALL or RETURN sequence SHALL discard the pending push or pop; the outputs SHALL be the reset values in the following cycle.
REQ-032 Reset SHALL have no asynchronous effect; outputs SHALL change only on clock edges.

Verification
REQ-033 Sequential and wrap: after reset, drive NOP for 3 cycles -> counter steps 0,1,2,3; force counter to 0x7FE and apply skip=1 on a SEQ opcode -> counter=0x000.
REQ-034 CALL/RETURN: at counter=0x005, CALL 0x123 -> counter=0x123, stack_ptr=1; then RETURN -> counter=0x006, stack_ptr=0.
REQ-035 RETLW: at depth 1 holding 0x040, RETLW k=0x5A -> counter=0x040, retlw_valid=1 for exactly one cycle, retlw_k=0x5A.
REQ-036 Overflow: 9 consecutive CALLs -> stk_ovf=1 after the 9th, stack_ptr=1; then 8 RETURNs -> counter follows return addresses 9..2; the 9th RETURN sets stk_unf=1.
REQ-037 Stall and skip priority: GOTO 0x200 with skip=1 -> counter=0x200; stall=1 for 3 cycles during a CALL -> no change to counter or stack_ptr until stall=0.
REQ-038 Reset mid-CALL: reset=1 coincident with a CALL at counter=0x010 -> next cycle counter=0, stack_ptr=0, both flags 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter sequencer with skip, goto, call/return and an 8-deep circular return stack.
module pc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] opcode,
    input  logic        skip,
    input  logic        stall,
    output logic [10:0] counter,
    output logic [2:0]  stack_ptr,
    output logic        stk_ovf,
    output logic        stk_unf,
    output logic        retlw_valid,
    output logic [7:0]  retlw_k
);
    logic [10:0] stack [8];
    logic [3:0]  depth;
    logic        is_goto, is_call, is_ret, is_retlw, is_pop;
    logic [2:0]  ptr_dec;
    logic [10:0] pc_inc, next_pc;
    always_comb begin
        is_goto  = opcode[13:11] == 3'b101;
        is_call  = opcode[13:11] == 3'b100;
        is_ret   = opcode == 14'h0008;
        is_retlw = opcode[13:10] == 4'b1101;
        is_pop   = is_ret || is_retlw;
        ptr_dec  = stack_ptr - 3'd1;
        pc_inc   = counter + 11'd1;
        next_pc  = (is_goto || is_call) ? opcode[10:0] :
                   is_pop ? stack[ptr_dec] :
                   skip ? counter + 11'd2 : pc_inc;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            counter     <= '0;
            stack_ptr   <= '0;
            depth       <= '0;
            stk_ovf     <= 1'b0;
            stk_unf     <= 1'b0;
            retlw_valid <= 1'b0;
            retlw_k     <= '0;
            for (int i = 0; i < 8; i++) stack[i] <= '0;
        end else if (stall) begin
            retlw_valid <= 1'b0;
        end else begin
            counter     <= next_pc;
            retlw_valid <= is_retlw;
            if (is_retlw) retlw_k <= opcode[7:0];
            // a full stack overwrites its oldest slot; an empty one still pops a stale entry
            if (is_call) begin
                stack[stack_ptr] <= pc_inc;
                stack_ptr        <= stack_ptr + 3'd1;
                if (depth == 4'd8) stk_ovf <= 1'b1;
                else depth <= depth + 4'd1;
            end else if (is_pop) begin
                stack_ptr <= ptr_dec;
                if (depth == 4'd0) stk_unf <= 1'b1;
                else depth <= depth - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with hand-computed expectations, checked through a scoreboard queue.
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        reset, skip, stall;
    logic [13:0] opcode;
    logic [10:0] counter;
    logic [2:0]  stack_ptr;
    logic        stk_ovf, stk_unf, retlw_valid;
    logic [7:0]  retlw_k;
    logic [24:0] exp_q [$];
    string       name_q [$];
    int          n_vec = 0;
    int          n_bad = 0;

    localparam logic [13:0] NOP = 14'h0000;
    localparam logic [13:0] RET = 14'h0008;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .skip(skip), .stall(stall),
        .counter(counter), .stack_ptr(stack_ptr), .stk_ovf(stk_ovf), .stk_unf(stk_unf),
        .retlw_valid(retlw_valid), .retlw_k(retlw_k)
    );

    function automatic logic [13:0] goto_op(input logic [10:0] t);
        return {3'b101, t};
    endfunction
    function automatic logic [13:0] call_op(input logic [10:0] t);
        return {3'b100, t};
    endfunction
    function automatic logic [13:0] retlw_op(input logic [7:0] k);
        return {4'b1101, 2'b00, k};
    endfunction
    function automatic logic [24:0] pack(input logic [10:0] c, input logic [2:0] sp,
                                         input logic o, input logic u, input logic v, input logic [7:0] k);
        return {c, sp, o, u, v, k};
    endfunction

    // expected state is what the outputs show after the edge that consumes this vector
    task automatic step(input logic [13:0] op, input logic sk, input logic st, input logic rs,
                        input logic [24:0] exp, input string nm);
        @(negedge clk);
        opcode = op; skip = sk; stall = st; reset = rs;
        exp_q.push_back(exp);
        name_q.push_back(nm);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [24:0] e, a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {counter, stack_ptr, stk_ovf, stk_unf, retlw_valid, retlw_k};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got pc=%h sp=%0d ovf=%b unf=%b rv=%b k=%h, want pc=%h sp=%0d ovf=%b unf=%b rv=%b k=%h",
                         nm, a[24:14], a[13:11], a[10], a[9], a[8], a[7:0],
                         e[24:14], e[13:11], e[10], e[9], e[8], e[7:0]);
            end
        end
    end

    initial begin
        opcode = NOP; skip = 1'b0; stall = 1'b0; reset = 1'b1;
        step(NOP, 0, 0, 1, pack(11'h000, 0, 0, 0, 0, 8'h00), "reset");
        for (int i = 1; i <= 3; i++) step(NOP, 0, 0, 0, pack(11'(i), 0, 0, 0, 0, 8'h00), "seq");
        step(goto_op(11'h7FE), 0, 0, 0, pack(11'h7FE, 0, 0, 0, 0, 8'h00), "goto_7fe");
        step(NOP, 1, 0, 0, pack(11'h000, 0, 0, 0, 0, 8'h00), "skip_wrap_7fe");
        step(goto_op(11'h7FF), 0, 0, 0, pack(11'h7FF, 0, 0, 0, 0, 8'h00), "goto_7ff");
        step(NOP, 0, 0, 0, pack(11'h000, 0, 0, 0, 0, 8'h00), "inc_wrap_7ff");
        step(goto_op(11'h7FF), 0, 0, 0, pack(11'h7FF, 0, 0, 0, 0, 8'h00), "goto_7ff_b");
        step(NOP, 1, 0, 0, pack(11'h001, 0, 0, 0, 0, 8'h00), "skip_wrap_7ff");
        step(goto_op(11'h005), 0, 0, 0, pack(11'h005, 0, 0, 0, 0, 8'h00), "goto_005");
        step(call_op(11'h123), 0, 0, 0, pack(11'h123, 1, 0, 0, 0, 8'h00), "call_123");
        step(RET, 0, 0, 0, pack(11'h006, 0, 0, 0, 0, 8'h00), "return_006");
        step(goto_op(11'h03F), 0, 0, 0, pack(11'h03F, 0, 0, 0, 0, 8'h00), "goto_03f");
        step(call_op(11'h300), 1, 0, 0, pack(11'h300, 1, 0, 0, 0, 8'h00), "call_300_skip");
        step(retlw_op(8'h5A), 1, 0, 0, pack(11'h040, 0, 0, 0, 1, 8'h5A), "retlw_5a");
        step(NOP, 0, 0, 0, pack(11'h041, 0, 0, 0, 0, 8'h5A), "retlw_pulse_end");
        step(NOP, 0, 0, 1, pack(11'h000, 0, 0, 0, 0, 8'h00), "reset_2");
        for (int i = 1; i <= 9; i++)
            step(call_op(11'(i)), 0, 0, 0, pack(11'(i), 3'(i), i == 9, 0, 0, 8'h00), "ovf_call");
        for (int j = 1; j <= 9; j++)
            step(RET, 0, 0, 0, pack(j <= 8 ? 11'(10 - j) : 11'd9, 3'(1 - j), 1, j == 9, 0, 8'h00), "unf_return");
        step(goto_op(11'h010), 0, 0, 0, pack(11'h010, 0, 1, 1, 0, 8'h00), "goto_010");
        step(call_op(11'h010), 0, 1, 1, pack(11'h000, 0, 0, 0, 0, 8'h00), "reset_mid_call");
        step(NOP, 0, 0, 0, pack(11'h001, 0, 0, 0, 0, 8'h00), "post_reset_seq");
        step(goto_op(11'h200), 1, 0, 0, pack(11'h200, 0, 0, 0, 0, 8'h00), "goto_200_skip");
        for (int i = 0; i < 3; i++)
            step(call_op(11'h050), 0, 1, 0, pack(11'h200, 0, 0, 0, 0, 8'h00), "stall_call");
        step(call_op(11'h050), 0, 0, 0, pack(11'h050, 1, 0, 0, 0, 8'h00), "call_050");
        step(retlw_op(8'hAB), 0, 0, 0, pack(11'h201, 0, 0, 0, 1, 8'hAB), "retlw_ab");
        step(retlw_op(8'hAB), 0, 1, 0, pack(11'h201, 0, 0, 0, 0, 8'hAB), "stall_retlw");
        step(NOP, 0, 0, 0, pack(11'h202, 0, 0, 0, 0, 8'hAB), "stall_release");
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
